ex_mem_reg: RTL and testbench

- EX/MEM pipeline register of the MIPS pipeline.
- Directly downstream of the EX-stage ALU control and ALU. It consumes the 4-bit ALU control code and the last-register select, together with the ALU result.
- Resolves BEQ/BNE and selects the link register and link data for JAL/JALR.
- Registers everything for the MEM stage, and provides squash, halt and debug-step behaviour.

---
 rtl/ex_mem_reg_pkg.sv | 6 +
 rtl/ex_mem_reg_branch_resolve.sv | 25 ++
 rtl/ex_mem_reg.sv | 160 ++++++++++++++++
 tb/tb_ex_mem_reg.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_reg_pkg.sv
// Shared constants for the EX/MEM pipeline register: branch ALU codes and link register.
package ex_mem_reg_pkg;
  localparam logic [3:0]  ALU_BEQ_CTRL     = 4'hb;
  localparam logic [3:0]  ALU_BNE_CTRL     = 4'hc;
  localparam int unsigned LINK_REG_DEFAULT = 31;
endpackage

// File: rtl/ex_mem_reg_branch_resolve.sv
// Combinational BEQ/BNE resolution: taken flag and PC-relative target.
module ex_mem_reg_branch_resolve
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned DATA_SIZE     = 32,
  parameter int unsigned ALU_CTRL_SIZE = 4
) (
  input  logic                     capture,
  input  logic [ALU_CTRL_SIZE-1:0] alu_ctrl,
  input  logic                     cond,
  input  logic [DATA_SIZE-1:0]     pc_plus4,
  input  logic [DATA_SIZE-1:0]     imm,
  output logic                     taken_c,
  output logic [DATA_SIZE-1:0]     target_c
);

  logic is_branch;

  assign is_branch = (alu_ctrl == ALU_CTRL_SIZE'(ALU_BEQ_CTRL)) ||
                     (alu_ctrl == ALU_CTRL_SIZE'(ALU_BNE_CTRL));
  // The ALU already evaluated equal/not-equal; bit 0 says whether it holds.
  assign taken_c  = capture & is_branch & cond;
  assign target_c = pc_plus4 + (imm << 2);

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch resolve, link select, squash and sticky halt.
// Optional bubble counter enabled by defining EX_MEM_BUBBLE_CNT_EN.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned DATA_SIZE     = 32,
  parameter int unsigned REG_ADDR_SIZE = 5,
  parameter int unsigned ALU_CTRL_SIZE = 4,
  parameter int unsigned LINK_REG      = LINK_REG_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic [ALU_CTRL_SIZE-1:0] i_alu_ctrl,
  input  logic                     i_last_register_ctrl,
  input  logic                     i_jal,
  input  logic [DATA_SIZE-1:0]     i_alu_result,
  input  logic [DATA_SIZE-1:0]     i_data_b,
  input  logic [DATA_SIZE-1:0]     i_imm,
  input  logic [DATA_SIZE-1:0]     i_pc_plus4,
  input  logic [REG_ADDR_SIZE-1:0] i_rd,
  input  logic [REG_ADDR_SIZE-1:0] i_rt,
  input  logic                     i_reg_dst,
  input  logic                     i_reg_write,
  input  logic                     i_mem_read,
  input  logic                     i_mem_write,
  input  logic                     i_mem_to_reg,
  input  logic [1:0]               i_mem_width,
  input  logic                     i_halt,
  output logic                     o_valid,
  output logic                     o_reg_write,
  output logic                     o_mem_read,
  output logic                     o_mem_write,
  output logic                     o_mem_to_reg,
  output logic [1:0]               o_mem_width,
  output logic [DATA_SIZE-1:0]     o_result,
  output logic [DATA_SIZE-1:0]     o_store_data,
  output logic [REG_ADDR_SIZE-1:0] o_write_reg,
  output logic                     o_branch_taken,
  output logic [DATA_SIZE-1:0]     o_branch_target,
`ifdef EX_MEM_BUBBLE_CNT_EN
  output logic [31:0]              o_bubble_cnt,
`endif
  output logic                     o_halt
);

  logic squash_next;
  logic halt_seen;
  logic bubble_c;
  logic taken_c;
  logic [DATA_SIZE-1:0] target_c;

  logic                     valid_n, reg_write_n, mem_read_n, mem_write_n, mem_to_reg_n;
  logic [1:0]               mem_width_n;
  logic [DATA_SIZE-1:0]     result_n, store_data_n, branch_target_n;
  logic [REG_ADDR_SIZE-1:0] write_reg_n;
  logic                     branch_taken_n, squash_n, halt_seen_n;

  assign bubble_c = i_flush | squash_next | halt_seen | ~i_valid;
  assign o_halt   = halt_seen;

  ex_mem_reg_branch_resolve #(
    .DATA_SIZE     (DATA_SIZE),
    .ALU_CTRL_SIZE (ALU_CTRL_SIZE)
  ) u_branch_resolve (
    .capture  (~bubble_c & ~i_halt),
    .alu_ctrl (i_alu_ctrl),
    .cond     (i_alu_result[0]),
    .pc_plus4 (i_pc_plus4),
    .imm      (i_imm),
    .taken_c  (taken_c),
    .target_c (target_c)
  );

  // Next-state: bubbles zero everything; a HALT capture is a valid slot with no side effects.
  always_comb begin
    valid_n         = 1'b0;
    reg_write_n     = 1'b0;
    mem_read_n      = 1'b0;
    mem_write_n     = 1'b0;
    mem_to_reg_n    = 1'b0;
    mem_width_n     = 2'b00;
    result_n        = '0;
    store_data_n    = '0;
    write_reg_n     = '0;
    branch_taken_n  = 1'b0;
    branch_target_n = '0;
    squash_n        = 1'b0;
    halt_seen_n     = halt_seen;
    if (!bubble_c) begin
      valid_n = 1'b1;
      if (i_halt) begin
        halt_seen_n = 1'b1;
      end else begin
        reg_write_n     = i_reg_write;
        mem_read_n      = i_mem_read;
        mem_write_n     = i_mem_write;
        mem_to_reg_n    = i_mem_to_reg;
        mem_width_n     = i_mem_width;
        store_data_n    = i_data_b;
        branch_taken_n  = taken_c;
        branch_target_n = target_c;
        squash_n        = taken_c;
        if (i_last_register_ctrl) begin
          result_n    = i_pc_plus4 + DATA_SIZE'(4);
          write_reg_n = i_jal ? REG_ADDR_SIZE'(LINK_REG) : i_rd;
        end else begin
          result_n    = i_alu_result;
          write_reg_n = i_reg_dst ? i_rd : i_rt;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_valid         <= 1'b0;
      o_reg_write     <= 1'b0;
      o_mem_read      <= 1'b0;
      o_mem_write     <= 1'b0;
      o_mem_to_reg    <= 1'b0;
      o_mem_width     <= 2'b00;
      o_result        <= '0;
      o_store_data    <= '0;
      o_write_reg     <= '0;
      o_branch_taken  <= 1'b0;
      o_branch_target <= '0;
      squash_next     <= 1'b0;
      halt_seen       <= 1'b0;
    end else if (i_enable) begin
      o_valid         <= valid_n;
      o_reg_write     <= reg_write_n;
      o_mem_read      <= mem_read_n;
      o_mem_write     <= mem_write_n;
      o_mem_to_reg    <= mem_to_reg_n;
      o_mem_width     <= mem_width_n;
      o_result        <= result_n;
      o_store_data    <= store_data_n;
      o_write_reg     <= write_reg_n;
      o_branch_taken  <= branch_taken_n;
      o_branch_target <= branch_target_n;
      squash_next     <= squash_n;
      halt_seen       <= halt_seen_n;
    end
  end

`ifdef EX_MEM_BUBBLE_CNT_EN
  // Counts only flush/squash bubbles, saturating.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_bubble_cnt <= '0;
    end else if (i_enable && (i_flush || squash_next) && (o_bubble_cnt != 32'hFFFF_FFFF)) begin
      o_bubble_cnt <= o_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized self-checking bench for ex_mem_reg against a cycle-level reference model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, flush, valid, lrc, jal, reg_dst;
  logic        reg_write, mem_read, mem_write, mem_to_reg, halt;
  logic [3:0]  alu_ctrl;
  logic [1:0]  mem_width;
  logic [31:0] alu_result, data_b, imm, pc_plus4;
  logic [4:0]  rd, rt;

  logic        o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic [1:0]  o_mem_width;
  logic [31:0] o_result, o_store_data, o_branch_target;
  logic [4:0]  o_write_reg;
  logic        o_branch_taken, o_halt;
`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [31:0] o_bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_squash, m_halt;
  logic        e_valid, e_rw, e_mr, e_mw, e_m2r, e_taken;
  logic [1:0]  e_width;
  logic [31:0] e_result, e_store, e_target, e_cnt;
  logic [4:0]  e_wreg;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .i_clk                (clk),
    .i_reset              (rst_n),
    .i_enable             (enable),
    .i_flush              (flush),
    .i_valid              (valid),
    .i_alu_ctrl           (alu_ctrl),
    .i_last_register_ctrl (lrc),
    .i_jal                (jal),
    .i_alu_result         (alu_result),
    .i_data_b             (data_b),
    .i_imm                (imm),
    .i_pc_plus4           (pc_plus4),
    .i_rd                 (rd),
    .i_rt                 (rt),
    .i_reg_dst            (reg_dst),
    .i_reg_write          (reg_write),
    .i_mem_read           (mem_read),
    .i_mem_write          (mem_write),
    .i_mem_to_reg         (mem_to_reg),
    .i_mem_width          (mem_width),
    .i_halt               (halt),
    .o_valid              (o_valid),
    .o_reg_write          (o_reg_write),
    .o_mem_read           (o_mem_read),
    .o_mem_write          (o_mem_write),
    .o_mem_to_reg         (o_mem_to_reg),
    .o_mem_width          (o_mem_width),
    .o_result             (o_result),
    .o_store_data         (o_store_data),
    .o_write_reg          (o_write_reg),
    .o_branch_taken       (o_branch_taken),
    .o_branch_target      (o_branch_target),
`ifdef EX_MEM_BUBBLE_CNT_EN
    .o_bubble_cnt         (o_bubble_cnt),
`endif
    .o_halt               (o_halt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear_outputs();
    e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_m2r = 0; e_taken = 0;
    e_width = 0; e_result = 0; e_store = 0; e_target = 0; e_wreg = 0;
  endtask

  task automatic model_reset();
    model_clear_outputs();
    m_squash = 0; m_halt = 0; e_cnt = 0;
  endtask

  // Applies one enabled/disabled clock edge worth of pipeline rules to the model.
  task automatic model_edge();
    bit is_bubble, br;
    if (!enable) return;
    is_bubble = flush || m_squash || m_halt || !valid;
    if ((flush || m_squash) && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 1;
    model_clear_outputs();
    if (is_bubble) begin
      m_squash = 0;
    end else if (halt) begin
      e_valid  = 1;
      m_halt   = 1;
      m_squash = 0;
    end else begin
      e_valid = 1; e_rw = reg_write; e_mr = mem_read; e_mw = mem_write; e_m2r = mem_to_reg;
      e_width = mem_width;
      e_store = data_b;
      if (lrc) begin
        e_result = pc_plus4 + 32'd4;
        e_wreg   = jal ? 5'd31 : rd;
      end else begin
        e_result = alu_result;
        e_wreg   = reg_dst ? rd : rt;
      end
      br       = (alu_ctrl == 4'd11 || alu_ctrl == 4'd12) && alu_result[0];
      e_taken  = br;
      e_target = pc_plus4 + imm * 32'd4;
      m_squash = br;
    end
  endtask

  task automatic check_all();
    check_eq("valid",      32'(o_valid),      32'(e_valid));
    check_eq("reg_write",  32'(o_reg_write),  32'(e_rw));
    check_eq("mem_read",   32'(o_mem_read),   32'(e_mr));
    check_eq("mem_write",  32'(o_mem_write),  32'(e_mw));
    check_eq("mem_to_reg", 32'(o_mem_to_reg), 32'(e_m2r));
    check_eq("mem_width",  32'(o_mem_width),  32'(e_width));
    check_eq("result",     o_result,          e_result);
    check_eq("store_data", o_store_data,      e_store);
    check_eq("write_reg",  32'(o_write_reg),  32'(e_wreg));
    check_eq("taken",      32'(o_branch_taken), 32'(e_taken));
    check_eq("target",     o_branch_target,   e_target);
    check_eq("halt",       32'(o_halt),       32'(m_halt));
`ifdef EX_MEM_BUBBLE_CNT_EN
    check_eq("bubble_cnt", o_bubble_cnt,      e_cnt);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_idle();
    enable = 1; flush = 0; valid = 1; lrc = 0; jal = 0; reg_dst = 0;
    reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; halt = 0;
    alu_ctrl = 4'h2; mem_width = 2'b10; alu_result = 0; data_b = 0; imm = 0;
    pc_plus4 = 0; rd = 0; rt = 0;
  endtask

  task automatic set_add(input logic [4:0] d, input logic [31:0] r);
    set_idle();
    rd = d; rt = 5'd9; reg_dst = 1; reg_write = 1; alu_result = r; data_b = 32'h1234;
  endtask

  task automatic set_beq(input logic [31:0] pc, input logic [31:0] offs);
    set_idle();
    alu_ctrl = 4'hb; alu_result = 32'h1; pc_plus4 = pc; imm = offs;
  endtask

  // Async reset applied between edges; outputs must clear without a clock.
  task automatic apply_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1;

    set_add(5'd5, 32'h0000_00A5);
    step();
    check_eq("add_wreg", 32'(o_write_reg), 32'd5);
    check_eq("add_res", o_result, 32'hA5);

    set_idle(); lrc = 1; jal = 1; pc_plus4 = 32'h40; rd = 5'd7; reg_write = 1;
    step();
    check_eq("jal_wreg", 32'(o_write_reg), 32'd31);
    check_eq("jal_res", o_result, 32'h44);

    set_beq(32'h100, 32'hFFFF_FFFE);
    step();
    check_eq("beq_taken", 32'(o_branch_taken), 32'd1);
    check_eq("beq_target", o_branch_target, 32'hF8);

    // Freeze for three cycles; squash must survive and apply on the next enabled edge.
    set_add(5'd3, 32'h55);
    enable = 0;
    repeat (3) step();
    check_eq("frozen_taken", 32'(o_branch_taken), 32'd1);
    enable = 1;
    step();
    check_eq("squash_bubble", 32'(o_valid), 32'd0);
    step();
    check_eq("after_squash", 32'(o_valid), 32'd1);

    set_beq(32'h200, 32'h10);
    flush = 1;
    step();
    check_eq("flush_beats_branch", 32'(o_branch_taken), 32'd0);

    set_idle(); halt = 1;
    step();
    check_eq("halt_set", 32'(o_halt), 32'd1);
    set_add(5'd4, 32'h77);
    repeat (3) step();
    check_eq("halt_no_write", 32'(o_reg_write), 32'd0);
    check_eq("halt_sticky", 32'(o_halt), 32'd1);

    apply_reset();
    set_add(5'd6, 32'h99);
    step();
    check_eq("pre_reset_valid", 32'(o_valid), 32'd1);
    apply_reset();
    check_eq("reset_valid", 32'(o_valid), 32'd0);

    set_add(5'd1, 32'h1); flush = 1;
    step(); step();
    set_beq(32'h300, 32'h4);
    step();
    set_add(5'd2, 32'h2);
    step();
`ifdef EX_MEM_BUBBLE_CNT_EN
    check_eq("cnt_three", o_bubble_cnt, 32'd3);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      enable     = ($urandom_range(0, 9) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      valid      = ($urandom_range(0, 6) != 0);
      halt       = ($urandom_range(0, 199) == 0);
      alu_ctrl   = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? 4'hb : 4'hc)
                                               : 4'($urandom_range(0, 15));
      lrc        = ($urandom_range(0, 4) == 0);
      jal        = 1'($urandom);
      reg_dst    = 1'($urandom);
      reg_write  = 1'($urandom);
      mem_read   = 1'($urandom);
      mem_write  = 1'($urandom);
      mem_to_reg = 1'($urandom);
      mem_width  = 2'($urandom);
      alu_result = $urandom;
      data_b     = $urandom;
      imm        = $urandom;
      pc_plus4   = $urandom;
      rd         = 5'($urandom);
      rt         = 5'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
